ad_trigger_capture: RTL and testbench

- Downstream of the 8-bit ADC sample register. Consumes one ADC sample per qualified cycle and performs edge triggering against a programmable level.
- Stores a pre-/post-trigger frame in an internal circular buffer.
- Presents the frame to the LCD waveform display through a trigger-aligned random read port, so trace x-position 0 is always the oldest pre-trigger sample.

---
 rtl/ad_trigger_capture.sv | 197 +++++++++++++++++++
 tb/tb_ad_trigger_capture.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_trigger_capture.sv
// ad_trigger_capture: edge-triggered ADC frame capture into a 2^ADDR_W-deep
// circular buffer, with a trigger-aligned registered read port (logical index
// 0 = oldest pre-trigger sample, PRE_TRIG = trigger sample).
// Optional build macro: AD_TRIG_CAPTURE_AUTO_TRIG_EN enables a forced trigger
// after AUTO_TIMEOUT valid samples in WAIT_TRIG; without it auto_trig is 0.
module ad_trigger_capture #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 8,
  parameter int PRE_TRIG     = 64,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              arm,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_ready,
  output logic              busy,
  output logic              auto_trig
);

  localparam int DEPTH = 1 << ADDR_W;

  if (PRE_TRIG < 1 || PRE_TRIG > DEPTH - 2 || AUTO_TIMEOUT < 1) begin : g_param_check
    $error("ad_trigger_capture: illegal PRE_TRIG or AUTO_TIMEOUT");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_FILL,
    S_WAIT_TRIG,
    S_POST_FILL,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] rd_phys;

  logic [DATA_W-1:0] mem [DEPTH];

  logic capturing;
  logic wr_en;
  logic arm_go;
  logic trig_hit;
  logic timeout_hit;
  logic fire;

`ifdef AD_TRIG_CAPTURE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            auto_trig_q, auto_trig_d;
`endif

  // Qualifiers shared by next-state and datapath logic
  always_comb begin
    capturing = (state_q == S_PRE_FILL) || (state_q == S_WAIT_TRIG) ||
                (state_q == S_POST_FILL);
    wr_en     = capturing && sample_valid;
    arm_go    = arm && ((state_q == S_IDLE) || (state_q == S_DONE));
    if (trig_slope)
      trig_hit = prev_valid_q && (prev_q > trig_level) && (sample_data <= trig_level);
    else
      trig_hit = prev_valid_q && (prev_q < trig_level) && (sample_data >= trig_level);
`ifdef AD_TRIG_CAPTURE_AUTO_TRIG_EN
    timeout_hit = (to_cnt_q == TO_W'(AUTO_TIMEOUT - 1));
`else
    timeout_hit = 1'b0;
`endif
    fire = wr_en && (state_q == S_WAIT_TRIG) && (trig_hit || timeout_hit);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (arm) state_d = S_PRE_FILL;
      S_PRE_FILL:     if (wr_en && cnt_q == ADDR_W'(PRE_TRIG - 1)) state_d = S_WAIT_TRIG;
      S_WAIT_TRIG:    if (fire) state_d = S_POST_FILL;
      S_POST_FILL:    if (wr_en && cnt_q == ADDR_W'(DEPTH - PRE_TRIG - 2)) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy        = capturing;
    frame_ready = (state_q == S_DONE);
    rd_data     = rd_data_q;
`ifdef AD_TRIG_CAPTURE_AUTO_TRIG_EN
    auto_trig   = auto_trig_q;
`else
    auto_trig   = 1'b0;
`endif
  end

  // Datapath next values: pointers, counters, trigger history
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    start_addr_d = start_addr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
`ifdef AD_TRIG_CAPTURE_AUTO_TRIG_EN
    to_cnt_d     = to_cnt_q;
    auto_trig_d  = auto_trig_q;
`endif
    if (arm_go) begin
      wr_ptr_d     = '0;
      cnt_d        = '0;
      prev_valid_d = 1'b0;
`ifdef AD_TRIG_CAPTURE_AUTO_TRIG_EN
      to_cnt_d     = '0;
      auto_trig_d  = 1'b0;
`endif
    end else if (wr_en) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      prev_d       = sample_data;
      prev_valid_d = 1'b1;
      case (state_q)
        S_PRE_FILL: begin
          if (cnt_q == ADDR_W'(PRE_TRIG - 1)) cnt_d = '0;
          else                                cnt_d = cnt_q + 1'b1;
        end
        S_WAIT_TRIG: begin
          if (fire) begin
            start_addr_d = wr_ptr_q - ADDR_W'(PRE_TRIG);
            cnt_d        = '0;
`ifdef AD_TRIG_CAPTURE_AUTO_TRIG_EN
            // A real crossing on the timeout sample wins, so auto_trig stays low.
            auto_trig_d  = ~trig_hit;
          end else begin
            to_cnt_d     = to_cnt_q + 1'b1;
`endif
          end
        end
        S_POST_FILL: cnt_d = cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      start_addr_q <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
`ifdef AD_TRIG_CAPTURE_AUTO_TRIG_EN
      to_cnt_q     <= '0;
      auto_trig_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      start_addr_q <= start_addr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
`ifdef AD_TRIG_CAPTURE_AUTO_TRIG_EN
      to_cnt_q     <= to_cnt_d;
      auto_trig_q  <= auto_trig_d;
`endif
    end
  end

  // Sample buffer write port (no reset, block-RAM friendly)
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample_data;
  end

  assign rd_phys = start_addr_q + rd_addr;

  // Registered trigger-aligned read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= mem[rd_phys];
  end

endmodule

// File: tb/tb_ad_trigger_capture.sv
// Self-checking bench for ad_trigger_capture. Frames are checked against a
// model that scans the recorded stream of accepted samples for the trigger
// and slices the expected frame out of it.
module tb_ad_trigger_capture;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int P      = 64;
  localparam int DEPTH  = 512;
`ifdef AD_TRIG_CAPTURE_AUTO_TRIG_EN
  localparam int AT = 16;
`else
  localparam int AT = 4096;
`endif

  logic              clk;
  logic              rst;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic              arm;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_ready;
  logic              busy;
  logic              auto_trig;

  ad_trigger_capture #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRE_TRIG(P), .AUTO_TIMEOUT(AT)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .trig_level(trig_level), .trig_slope(trig_slope), .arm(arm), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_ready(frame_ready), .busy(busy), .auto_trig(auto_trig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int addr;
    int exp;
  } vec_t;

  vec_t vt[11];
  int   checks;
  int   errors;
  int   stream[$];

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  function automatic int gen(input int mode, input int i);
    case (mode)
      0:       return i % 256;
      1:       return 255 - (i % 256);
      2:       return (i < 64) ? ((i % 2) ? 200 : 0) : ((i < 300) ? 0 : 150);
      3:       return int'($urandom_range(0, 255));
      default: return 0;
    endcase
  endfunction

  // First accepted sample at or after index P whose crossing matches the rules
  function automatic int find_trig(input int lvl, input int slp, output bit au);
    au = 1'b0;
    for (int t = P; t < stream.size(); t++) begin
      bit hit;
      if (slp == 0) hit = (stream[t-1] < lvl) && (stream[t] >= lvl);
      else          hit = (stream[t-1] > lvl) && (stream[t] <= lvl);
      if (hit) return t;
`ifdef AD_TRIG_CAPTURE_AUTO_TRIG_EN
      if (t - P + 1 == AT) begin
        au = 1'b1;
        return t;
      end
`endif
    end
    return -1;
  endfunction

  task automatic check_frame(input int id, input int lvl, input int slp);
    int t;
    bit au;
    t = find_trig(lvl, slp, au);
    chk("busy_done", id, int'(busy), 0);
    chk("frame_ready", id, int'(frame_ready), 1);
    if (t < 0) begin
      chk("trigger_found", id, 0, 1);
    end else begin
      chk("auto_trig", id, int'(auto_trig), int'(au));
      chk("write_count", id, stream.size(), t + DEPTH - P);
      for (int k = 0; k < DEPTH; k++) begin
        rd_addr = ADDR_W'(k);
        @(negedge clk);
        if (t - P + k < stream.size()) chk("rd_model", k, int'(rd_data), stream[t-P+k]);
      end
      foreach (vt[v]) begin
        if (vt[v].id == id) begin
          rd_addr = ADDR_W'(vt[v].addr);
          @(negedge clk);
          chk("rd_vec", vt[v].addr, int'(rd_data), vt[v].exp);
        end
      end
    end
  endtask

  // Arm, stream samples until frame_ready (bounded), then verify the frame
  task automatic capture(input int id, input int mode, input int gap, input int lvl,
                         input int slp, input int arm_at);
    int cyc;
    int i;
    bit v;
    bit ok;
    @(negedge clk);
    trig_level   = DATA_W'(lvl);
    trig_slope   = slp[0];
    sample_valid = 1'b0;
    arm          = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk("arm_clears_frame_ready", id, int'(frame_ready), 0);
    chk("arm_sets_busy", id, int'(busy), 1);
    stream.delete();
    i   = 0;
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 20000) begin
      if (frame_ready) begin
        ok = 1'b1;
        break;
      end
      if (gap == 0)      v = 1'b1;
      else if (gap == 1) v = (cyc % 2 == 0);
      else               v = ($urandom_range(0, 3) != 0);
      arm          = (cyc == arm_at);
      sample_valid = v;
      if (v) begin
        sample_data = DATA_W'(gen(mode, i));
        stream.push_back(int'(sample_data));
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    sample_valid = 1'b0;
    arm          = 1'b0;
    chk("frame_done_in_budget", id, int'(ok), 1);
    if (ok) check_frame(id, lvl, slp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    // Rising ramp, level 100: trigger sample index 100, frame = stream[36..547]
    vt[0]  = '{0, 64, 100};
    vt[1]  = '{0, 0, 36};
    vt[2]  = '{0, 511, 35};
    vt[3]  = '{0, 100, 136};
    // Falling ramp with gaps, level 50: trigger index 205, frame = stream[141..652]
    vt[4]  = '{1, 64, 50};
    vt[5]  = '{1, 0, 114};
    vt[6]  = '{1, 511, 115};
    // Pre-fill masking: trigger is the first 150 at index 300
    vt[7]  = '{2, 64, 150};
    vt[8]  = '{2, 63, 0};
    vt[9]  = '{2, 0, 0};
    vt[10] = '{2, 65, 150};

    rst = 1'b1; arm = 1'b0; sample_valid = 1'b0; sample_data = '0;
    trig_level = '0; trig_slope = 1'b0; rd_addr = '0;
    #12;
    chk("reset_busy", 0, int'(busy), 0);
    chk("reset_frame_ready", 0, int'(frame_ready), 0);
    chk("reset_auto_trig", 0, int'(auto_trig), 0);
    chk("reset_rd_data", 0, int'(rd_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // Rising ramp with a stray arm pulse while waiting for the trigger
    capture(0, 0, 0, 100, 0, 80);
    // Falling ramp with alternating valid (re-arm from DONE)
    capture(1, 1, 1, 50, 1, -1);
    // Crossings during pre-fill must not trigger
    capture(2, 2, 0, 100, 0, -1);
    // Random data, level, slope and gaps
    for (int r = 0; r < 3; r++)
      capture(10 + r, 3, 2, int'($urandom_range(1, 254)), int'($urandom_range(0, 1)), -1);

    // Asynchronous reset in POST_FILL
    @(negedge clk);
    trig_level = 8'd100; trig_slope = 1'b0; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    rd_addr = 9'd64;
    for (int j = 0; j < 200; j++) begin
      sample_valid = 1'b1;
      sample_data  = DATA_W'(j % 256);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("pre_reset_busy", 5, int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_busy", 5, int'(busy), 0);
    chk("async_reset_frame_ready", 5, int'(frame_ready), 0);
    chk("async_reset_rd_data", 5, int'(rd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset_busy", 5, int'(busy), 0);
    capture(5, 0, 0, 100, 0, -1);

`ifdef AD_TRIG_CAPTURE_AUTO_TRIG_EN
    // Constant zero never crosses: forced trigger after AT samples in WAIT_TRIG
    capture(4, 4, 0, 100, 0, -1);
`else
    // Constant zero never crosses: capture must stay busy
    @(negedge clk);
    trig_level = 8'd100; trig_slope = 1'b0; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    for (int j = 0; j < 3000; j++) begin
      sample_valid = 1'b1;
      sample_data  = '0;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("no_trigger_busy", 4, int'(busy), 1);
    chk("no_trigger_frame_ready", 4, int'(frame_ready), 0);
    chk("no_trigger_auto_trig", 4, int'(auto_trig), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
